// File: rtl/attn_seq_core.sv
// Sequential single-head attention core: loads Q/K/V, computes scores, optional
// min-shift/square normalisation, output MAC, then streams O row-major.
module attn_seq_core #(
    parameter int N     = 8,
    parameter int D     = 4,
    parameter int DW    = 16,
    parameter int FRAC  = 8,
    parameter int ACC_W = 36
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          start,
    input  logic          norm_bypass,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          busy,
    output logic          done,
    output logic          sat_flag
);

    localparam int ND = N * D;
    localparam int NN = N * N;
    localparam int LW = $clog2(3 * ND);
    localparam int OW = $clog2(ND);
    localparam int MW = $clog2(NN);
    localparam int NW = $clog2(N);
    localparam int CW = $clog2((N > D) ? N : D) + 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SCORE, S_MIN, S_NORM, S_OUTMAC, S_DRAIN
    } state_t;

    state_t           r_state;
    logic             r_bypass;
    logic [LW-1:0]    r_ld;
    logic [CW-1:0]    r_a, r_b, r_c;
    logic [ACC_W-1:0] r_acc;
    logic [DW-1:0]    r_min;
    logic [OW-1:0]    r_oidx;

    logic [DW-1:0] r_q [ND];
    logic [DW-1:0] r_k [ND];
    logic [DW-1:0] r_v [ND];
    logic [DW-1:0] r_s [NN];
    logic [DW-1:0] r_m [N];
    logic [DW-1:0] r_o [ND];

    logic [CW-1:0]    w_c_lim, w_b_lim, w_a_nxt, w_b_nxt, w_c_nxt;
    logic             w_c_last, w_b_last, w_a_last, w_all_last;
    logic [MW-1:0]    w_s_addr;
    logic [DW-1:0]    w_s_cur, w_diff, w_min_nxt, w_op_a, w_op_b, w_q_val;
    logic [2*DW-1:0]  w_prod;
    logic [ACC_W-1:0] w_acc_nxt, w_q_in;
    logic [DW:0]      w_q_res;
    logic             w_q_sat;

    // Round half up and clamp to DW bits; MSB of the result flags saturation.
    function automatic logic [DW:0] quant(input logic [ACC_W-1:0] x);
        logic [ACC_W:0] t;
        logic           sat;
        t   = ({1'b0, x} + ((ACC_W+1)'(1) << (FRAC - 1))) >> FRAC;
        sat = |t[ACC_W:DW];
        return {sat, sat ? {DW{1'b1}} : t[DW-1:0]};
    endfunction

    // Loop limits: inner index is k in SCORE, j in OUTMAC, unused in MIN/NORM.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        w_c_lim = '0;
        w_b_lim = CW'(N - 1);
        case (r_state)
            S_SCORE:  w_c_lim = CW'(D - 1);
            S_OUTMAC: begin
                w_c_lim = CW'(N - 1);
                w_b_lim = CW'(D - 1);
            end
            default: ;
        endcase
    end

    assign w_c_last   = (r_c == w_c_lim);
    assign w_b_last   = (r_b == w_b_lim);
    assign w_a_last   = (r_a == CW'(N - 1));
    assign w_all_last = w_c_last & w_b_last & w_a_last;

    always_comb begin
        w_a_nxt = r_a;
        w_b_nxt = r_b;
        w_c_nxt = r_c + CW'(1);
        if (w_c_last) begin
            w_c_nxt = '0;
            if (w_b_last) begin
                w_b_nxt = '0;
                w_a_nxt = w_a_last ? '0 : r_a + CW'(1);
            end else begin
                w_b_nxt = r_b + CW'(1);
            end
        end
    end

    assign w_s_addr  = MW'(r_a * N + r_b);
    assign w_s_cur   = r_s[w_s_addr];
    assign w_diff    = w_s_cur - r_m[NW'(r_a)];
    assign w_min_nxt = (r_b == '0 || w_s_cur < r_min) ? w_s_cur : r_min;

    // The single shared multiplier: Q*K, diff^2 or P*V depending on stage.
    always_comb begin
        w_op_a = '0;
        w_op_b = '0;
        case (r_state)
            S_SCORE: begin
                w_op_a = r_q[OW'(r_a * D + r_c)];
                w_op_b = r_k[OW'(r_b * D + r_c)];
            end
            S_NORM: begin
                w_op_a = w_diff;
                w_op_b = w_diff;
            end
            S_OUTMAC: begin
                w_op_a = r_s[MW'(r_a * N + r_c)];
                w_op_b = r_v[OW'(r_c * D + r_b)];
            end
            default: ;
        endcase
    end

    assign w_prod    = w_op_a * w_op_b;
    assign w_acc_nxt = ((r_c == '0) ? '0 : r_acc) + ACC_W'(w_prod);
    assign w_q_in    = (r_state == S_NORM) ? ACC_W'(w_prod) : w_acc_nxt;
    assign w_q_res   = quant(w_q_in);
    assign w_q_val   = w_q_res[DW-1:0];
    assign w_q_sat   = w_q_res[DW];

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operand/result memories are deliberately left out of reset; every job rewrites them before use.
            r_state   <= S_IDLE;
            r_bypass  <= 1'b0;
            r_ld      <= '0;
            r_a       <= '0;
            r_b       <= '0;
            r_c       <= '0;
            r_acc     <= '0;
            r_min     <= '0;
            r_oidx    <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sat_flag  <= 1'b0;
        end else if (en) begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_bypass <= norm_bypass;
                    sat_flag <= 1'b0;
                    r_ld     <= '0;
                    r_a      <= '0;
                    r_b      <= '0;
                    r_c      <= '0;
                    in_ready <= 1'b1;
                    busy     <= 1'b1;
                    r_state  <= S_LOAD;
                end
                S_LOAD: if (in_valid) begin
                    if (r_ld < LW'(ND))          r_q[OW'(r_ld)]                <= in_data;
                    else if (r_ld < LW'(2 * ND)) r_k[OW'(r_ld - LW'(ND))]     <= in_data;
                    else                         r_v[OW'(r_ld - LW'(2 * ND))] <= in_data;
                    if (r_ld == LW'(3 * ND - 1)) begin
                        in_ready <= 1'b0;
                        r_state  <= S_SCORE;
                    end else begin
                        r_ld <= r_ld + LW'(1);
                    end
                end
                S_SCORE: begin
                    r_acc <= w_acc_nxt;
                    {r_a, r_b, r_c} <= {w_a_nxt, w_b_nxt, w_c_nxt};
                    if (w_c_last) begin
                        r_s[w_s_addr] <= w_q_val;
                        if (w_q_sat) sat_flag <= 1'b1;
                    end
                    if (w_all_last) r_state <= r_bypass ? S_OUTMAC : S_MIN;
                end
                S_MIN: begin
                    r_min <= w_min_nxt;
                    {r_a, r_b, r_c} <= {w_a_nxt, w_b_nxt, w_c_nxt};
                    if (w_b_last) r_m[NW'(r_a)] <= w_min_nxt;
                    if (w_all_last) r_state <= S_NORM;
                end
                S_NORM: begin
                    r_s[w_s_addr] <= w_q_val;
                    if (w_q_sat) sat_flag <= 1'b1;
                    {r_a, r_b, r_c} <= {w_a_nxt, w_b_nxt, w_c_nxt};
                    if (w_all_last) r_state <= S_OUTMAC;
                end
                S_OUTMAC: begin
                    r_acc <= w_acc_nxt;
                    {r_a, r_b, r_c} <= {w_a_nxt, w_b_nxt, w_c_nxt};
                    if (w_c_last) begin
                        r_o[OW'(r_a * D + r_b)] <= w_q_val;
                        if (w_q_sat) sat_flag <= 1'b1;
                    end
                    if (w_all_last) begin
                        r_oidx    <= '0;
                        out_valid <= 1'b1;
                        out_data  <= r_o[OW'(0)];
                        out_last  <= 1'b0;
                        r_state   <= S_DRAIN;
                    end
                end
                S_DRAIN: if (out_ready) begin
                    if (r_oidx == OW'(ND - 1)) begin
                        out_valid <= 1'b0;
                        out_data  <= '0;
                        out_last  <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        r_state   <= S_IDLE;
                    end else begin
                        r_oidx   <= r_oidx + OW'(1);
                        out_data <= r_o[r_oidx + OW'(1)];
                        out_last <= (r_oidx == OW'(ND - 2));
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/attn_seq_core.md
ATTN_SEQ_CORE -- requirements
Module: attn_seq_core

Interface
REQ-001 SHALL have parameter N, default 8: token count (rows of Q, K, V), N >= 2.
REQ-002 SHALL have parameter D, default 4: head dimension (columns of Q, K, V), D >= 1.
REQ-003 SHALL have parameter DW, default 16: unsigned fixed-point data width.
REQ-004 SHALL have parameter FRAC, default 8: fractional bits of DW format.
REQ-005 SHALL have parameter ACC_W, default 36: accumulator width, ACC_W >= 2*DW+clog2(max(N,D)).
REQ-006 SHALL have ports: clk  in  1  sole clock, rising edge; rst  in  1  reset, synchronous, active-high.
REQ-007 SHALL have ports: en  in  1  global enable; start  in  1  job request; norm_bypass  in  1  skip min/square stage.
REQ-008 SHALL have ports: in_valid  in  1; in_ready  out  1; in_data  in  DW  operand stream.
REQ-009 SHALL have ports: out_valid  out  1; out_ready  in  1; out_data  out  DW; out_last  out  1  final result beat.
REQ-010 SHALL have ports: busy  out  1  job active; done  out  1  one-cycle job-complete pulse; sat_flag  out  1  sticky saturation indicator.

Function
REQ-011 SHALL implement states IDLE, LOAD, SCORE, MIN, NORM, OUTMAC, DRAIN; busy=1 in every state except IDLE.
REQ-012 SHALL, in IDLE, on start=1: latch norm_bypass, clear sat_flag, go to LOAD; start in any other state SHALL be ignored.
REQ-013 SHALL assert in_ready only in LOAD; each cycle with in_valid&in_ready stores one word; order Q row-major (N*D), then K row-major (N*D), then V row-major (N*D); after beat 3*N*D go to SCORE.
REQ-014 SHALL use one DWxDW unsigned multiplier and one ACC_W accumulator, one product per cycle, time-shared by all stages.
REQ-015 SHALL, in SCORE, compute S[i][j] = quant(sum_k Q[i][k]*K[j][k]), i,j row-major, D cycles per element, result written on the cycle of the last product; N*N*D cycles total.
REQ-016 quant(x) SHALL be: r = (x >> FRAC) + x[FRAC-1] (round half up); if r > 2^DW-1 result = 2^DW-1 and sat_flag set, else result = r.
REQ-017 SHALL, in MIN, find m[i] = min over j of S[i][j], one compare per cycle, N*N cycles; ties have no effect.
REQ-018 SHALL, in NORM, overwrite P[i][j] = quant((S[i][j]-m[i])^2), one element per cycle, N*N cycles.
REQ-019 SHALL, when latched norm_bypass=1, skip MIN and NORM (SCORE goes directly to OUTMAC) with P = S.
REQ-020 SHALL, in OUTMAC, compute O[i][d] = quant(sum_j P[i][j]*V[j][d]), row-major, N cycles per element, N*N*D cycles total.
REQ-021 SHALL, in DRAIN, present O row-major: out_valid=1, out_data and out_last held stable while out_ready=0; advance only on out_valid&out_ready; out_last=1 only on beat N*D.
REQ-022 SHALL, on the final DRAIN handshake, return to IDLE and pulse done=1 for exactly one cycle; sat_flag SHALL hold until the next accepted start.
REQ-023 SHALL, while en=0, freeze all state, counters, memories and outputs (no handshake completes); resumption continues exactly where frozen.
REQ-024 SHALL treat all operands and intermediate values as unsigned; subtraction in NORM cannot underflow because m[i] <= S[i][j].
REQ-025 Default-parameter latency start->first out_valid SHALL be 1+96+256+64+64+256 cycles with in_valid held high (bypass: 1+96+256+256).

Reset
REQ-026 SHALL, on rst=1 at a clock edge, go to IDLE and drive in_ready=0, out_valid=0, out_data=0, out_last=0, busy=0, done=0, sat_flag=0, regardless of en or current state.
REQ-027 SHALL abort any job in progress on reset; internal memories need not be cleared; the next start SHALL produce correct results.

Verification
REQ-028 All Q=K=V=0x0100, bypass=0 -> S=0x0400 everywhere, P=0, all 32 out_data=0x0000, sat_flag=0, done pulses once.
REQ-029 All Q=K=V=0x0100, bypass=1 -> all 32 out_data=0x2000 (8 x 4.0 x 1.0), first out_valid at cycle 609 after start.
REQ-030 Q[0][0]=0x0001, K[0][0]=0x0080, V[0][0]=0x0100, rest 0, bypass=1 -> S[0][0]=0x0001 (round-up), O[0][0]=0x0001, other outputs 0.
REQ-031 All Q=K=0xFFFF, V=0x0100, bypass=1 -> S saturates 0xFFFF, sat_flag=1 through done; next job with zero data -> sat_flag=0.
REQ-032 out_ready low 10 cycles at DRAIN beat 5, en low 5 cycles mid-SCORE -> no lost/duplicated beats, out_data stable while stalled, out_last on beat 32 only.
REQ-033 rst=1 for one cycle mid-SCORE, then full job -> busy=0, in_ready=0, out_valid=0 after reset edge; second job output matches REQ-028.
